dump_memory: RTL and testbench

Parametrised, byte-lane-writable single-clock data memory for the pipeline's memory stage. Adds three things to the main read/write port: a configurable word width, a streaming debug dump engine with valid/ready handshake, and an optional post-reset clear sweep. The dump engine feeds the debug unit, which serialises the full memory image out to the host without stalling the pipeline port.

---
 rtl/dump_memory.sv | 158 +++++++++++++++
 tb/tb_dump_memory.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dump_memory.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dump_memory: byte-lane data memory with streaming dump port; optional clear
// sweep after reset compiled in with MEMORY_CLEAR_EN.            Rev 1.0
// ---------------------------------------------------------------------------
module dump_memory #(
  parameter int    NB_DATA    = 32,
  parameter int    N_ADDRESS  = 32,
  parameter int    NB_ADDRESS = $clog2(N_ADDRESS),
  parameter int    N_BYTES    = NB_DATA / 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_r_en,
  input  logic [N_BYTES-1:0]    i_w_en,
  input  logic [NB_ADDRESS-1:0] i_addr,
  input  logic [NB_DATA-1:0]    i_w_data,
  output logic [NB_DATA-1:0]    o_r_data,
  input  logic                  i_d_start,
  input  logic                  i_d_ready,
  output logic                  o_d_valid,
  output logic [NB_DATA-1:0]    o_d_data,
  output logic [NB_ADDRESS-1:0] o_d_addr,
  output logic                  o_d_done,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);
`ifdef MEMORY_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  logic [NB_DATA-1:0] mem [N_ADDRESS];

  state_t                state_q,   state_d;
  logic [NB_ADDRESS-1:0] ptr_q,     ptr_d;
  logic [NB_DATA-1:0]    r_data_q,  r_data_d;
  logic [NB_DATA-1:0]    d_data_q,  d_data_d;
  logic [NB_ADDRESS-1:0] d_addr_q,  d_addr_d;
  logic                  d_valid_q, d_valid_d;
  logic                  d_done_q,  d_done_d;

  logic                  clearing;
  logic                  xfer;
  logic [NB_ADDRESS-1:0] ptr_inc;

  assign clearing = (state_q == CLEAR);
  assign xfer     = d_valid_q & i_d_ready;
  assign ptr_inc  = ptr_q + 1'b1;

  // Storage has no reset; the sweep (when built in) owns the write port.
  always_ff @(negedge i_clk) begin
    if (clearing) begin
      mem[ptr_q] <= '0;
    end else if (i_en) begin
      for (int k = 0; k < N_BYTES; k++) begin
        if (i_w_en[k]) mem[i_addr][8*k +: 8] <= i_w_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    r_data_d  = r_data_q;
    d_data_d  = d_data_q;
    d_addr_d  = d_addr_q;
    d_valid_d = d_valid_q;
    d_done_d  = 1'b0;

    // Read-first: mem still holds the pre-write value on this edge.
    if (clearing) begin
      r_data_d = '0;
    end else if (i_en) begin
      r_data_d = i_r_en ? mem[i_addr] : '0;
    end

    case (state_q)
`ifdef MEMORY_CLEAR_EN
      CLEAR: begin
        ptr_d = ptr_inc;
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = IDLE;
        end
      end
`endif
      IDLE: begin
        if (i_d_start) begin
          d_data_d  = mem[0];
          d_addr_d  = '0;
          d_valid_d = 1'b1;
          state_d   = DUMP;
        end
      end
      DUMP: begin
        if (xfer) begin
          if (ptr_q == LAST_ADDR) begin
            d_valid_d = 1'b0;
            d_done_d  = 1'b1;
            ptr_d     = '0;
            state_d   = DONE;
          end else begin
            ptr_d    = ptr_inc;
            d_data_d = mem[ptr_inc];
            d_addr_d = ptr_inc;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RESET_STATE;
      ptr_q     <= '0;
      r_data_q  <= '0;
      d_data_q  <= '0;
      d_addr_q  <= '0;
      d_valid_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      r_data_q  <= r_data_d;
      d_data_q  <= d_data_d;
      d_addr_q  <= d_addr_d;
      d_valid_q <= d_valid_d;
      d_done_q  <= d_done_d;
    end
  end

  assign o_r_data  = r_data_q;
  assign o_d_data  = d_data_q;
  assign o_d_addr  = d_addr_q;
  assign o_d_valid = d_valid_q;
  assign o_d_done  = d_done_q;
`ifdef MEMORY_CLEAR_EN
  assign o_busy    = clearing;
`else
  assign o_busy    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dump_memory.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dump_memory: directed self-checking bench; clear-sweep checks run only
// when MEMORY_CLEAR_EN is defined.                                Rev 1.0
// ---------------------------------------------------------------------------
module tb_dump_memory;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        i_r_en = 1'b0;
  logic [3:0]  i_w_en = 4'h0;
  logic [4:0]  i_addr = 5'd0;
  logic [31:0] i_w_data = 32'h0;
  logic [31:0] o_r_data;
  logic        i_d_start = 1'b0;
  logic        i_d_ready = 1'b0;
  logic        o_d_valid;
  logic [31:0] o_d_data;
  logic [4:0]  o_d_addr;
  logic        o_d_done;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  dump_memory #(.NB_DATA(32), .N_ADDRESS(32)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_r_en(i_r_en),
    .i_w_en(i_w_en), .i_addr(i_addr), .i_w_data(i_w_data), .o_r_data(o_r_data),
    .i_d_start(i_d_start), .i_d_ready(i_d_ready), .o_d_valid(o_d_valid),
    .o_d_data(o_d_data), .o_d_addr(o_d_addr), .o_d_done(o_d_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One active (falling) edge; returns at the following rising edge.
  task automatic step();
    @(negedge i_clk);
    @(posedge i_clk);
  endtask

  task automatic mem_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] we);
    i_en = 1'b1; i_r_en = 1'b0; i_w_en = we; i_addr = a; i_w_data = d;
    step();
    i_en = 1'b0; i_w_en = 4'h0;
  endtask

  task automatic mem_read(input logic [4:0] a, output logic [31:0] d);
    i_en = 1'b1; i_r_en = 1'b1; i_w_en = 4'h0; i_addr = a;
    step();
    d = o_r_data;
    i_en = 1'b0; i_r_en = 1'b0;
  endtask

  task automatic wait_not_busy();
    int cnt = 0;
    while (o_busy && cnt < 40) begin
      step();
      cnt++;
    end
    check("busy_timeout", {63'd0, o_busy}, 64'd0);
  endtask

  logic [31:0] rd;
  int          cnt;

  initial begin
    // Reset state
    #1;
    check("rst_r_data",  {32'd0, o_r_data}, 64'd0);
    check("rst_d_ctrl",  {57'd0, o_d_valid, o_d_done, o_d_addr}, 64'd0);
    check("rst_d_data",  {32'd0, o_d_data}, 64'd0);
`ifdef MEMORY_CLEAR_EN
    check("rst_busy", {63'd0, o_busy}, 64'd1);
`else
    check("rst_busy", {63'd0, o_busy}, 64'd0);
`endif
    @(posedge i_clk);
    i_rst_n = 1'b1;
    step();

`ifdef MEMORY_CLEAR_EN
    wait_not_busy();
    mem_write(5'd5, 32'hDEADBEEF, 4'hF);
    i_rst_n = 1'b0;
    #1;
    check("clr_busy_rst", {63'd0, o_busy}, 64'd1);
    @(posedge i_clk);
    i_rst_n = 1'b1;
    // Writes held on the port throughout the sweep must be dropped.
    i_en = 1'b1; i_r_en = 1'b1; i_w_en = 4'hF; i_addr = 5'd20; i_w_data = 32'h55555555;
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 25) check("clr_r_data_forced", {32'd0, o_r_data}, 64'd0);
    end while (o_busy && cnt < 40);
    check("clr_busy_edges", cnt, 64'd32);
    i_en = 1'b0; i_r_en = 1'b0; i_w_en = 4'h0;
    mem_read(5'd5, rd);
    check("clr_addr5", {32'd0, rd}, 64'd0);
    mem_read(5'd20, rd);
    check("clr_write_dropped", {32'd0, rd}, 64'd0);
`endif

    // Byte lanes
    mem_write(5'd3, 32'hAABBCCDD, 4'b1111);
    mem_write(5'd3, 32'h11223344, 4'b0101);
    mem_read(5'd3, rd);
    check("lanes_addr3", {32'd0, rd}, {32'd0, 32'hAA22CC44});

    // Read-first, read-disabled, and hold
    mem_write(5'd7, 32'h0, 4'hF);
    i_en = 1'b1; i_r_en = 1'b1; i_w_en = 4'hF; i_addr = 5'd7; i_w_data = 32'h12345678;
    step();
    check("rf_same_edge", {32'd0, o_r_data}, 64'd0);
    i_w_en = 4'h0;
    step();
    check("rf_next_read", {32'd0, o_r_data}, {32'd0, 32'h12345678});
    i_r_en = 1'b0;
    step();
    check("ren_low_zero", {32'd0, o_r_data}, 64'd0);
    mem_read(5'd7, rd);
    step();
    check("en_low_hold", {32'd0, o_r_data}, {32'd0, 32'h12345678});

    // Dump with ready toggling every edge
    for (int k = 0; k < 32; k++) mem_write(5'(k), 32'(k) * 32'h01010101, 4'hF);
    i_d_start = 1'b1; i_d_ready = 1'b0;
    step();
    i_d_start = 1'b0;
    for (int w = 0; w < 32; w++) begin
      check($sformatf("dump_word%0d", w), {o_d_valid, 26'd0, o_d_addr, o_d_data},
            {1'b1, 26'd0, 5'(w), 32'(w) * 32'h01010101});
      i_d_ready = 1'b0;
      step();
      check($sformatf("dump_stall%0d", w), {o_d_valid, 26'd0, o_d_addr, o_d_data},
            {1'b1, 26'd0, 5'(w), 32'(w) * 32'h01010101});
      i_d_ready = 1'b1;
      step();
    end
    check("dump_done_pulse", {62'd0, o_d_done, o_d_valid}, 64'd2);
    i_d_ready = 1'b0;
    step();
    check("dump_done_clear", {62'd0, o_d_done, o_d_valid}, 64'd0);

    // Collision while word 4 is stalled
    i_d_start = 1'b1;
    step();
    i_d_start = 1'b0;
    i_d_ready = 1'b1;
    repeat (4) step();
    i_d_ready = 1'b0;
    mem_write(5'd4, 32'hFFFFFFFF, 4'hF);
    mem_write(5'd6, 32'hFFFFFFFF, 4'hF);
    check("coll_addr4_old", {27'd0, o_d_addr, o_d_data}, {27'd0, 5'd4, 32'h04040404});
    i_d_ready = 1'b1;
    step();
    check("coll_addr5", {27'd0, o_d_addr, o_d_data}, {27'd0, 5'd5, 32'h05050505});
    step();
    check("coll_addr6_new", {27'd0, o_d_addr, o_d_data}, {27'd0, 5'd6, 32'hFFFFFFFF});
    cnt = 0;
    while (!o_d_done && cnt < 40) begin
      step();
      cnt++;
    end
    check("coll_done_seen", {63'd0, o_d_done}, 64'd1);
    i_d_ready = 1'b0;
    step();

    // Reset mid-dump
    i_d_start = 1'b1;
    step();
    i_d_start = 1'b0;
    i_d_ready = 1'b1;
    repeat (11) step();
    check("mid_addr11", {27'd0, o_d_addr, o_d_data}, {27'd0, 5'd11, 32'h0B0B0B0B});
    i_d_ready = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {o_d_valid, o_d_done, 25'd0, o_d_addr, o_d_data}, 64'd0);
    @(posedge i_clk);
    i_rst_n = 1'b1;
`ifdef MEMORY_CLEAR_EN
    step();
    wait_not_busy();
`endif
    i_d_start = 1'b1;
    step();
    i_d_start = 1'b0;
    check("restart_addr0", {o_d_valid, 26'd0, o_d_addr, o_d_data}, {1'b1, 63'd0});
    i_d_ready = 1'b1;
    step();
`ifdef MEMORY_CLEAR_EN
    check("restart_addr1", {27'd0, o_d_addr, o_d_data}, {27'd0, 5'd1, 32'h0});
`else
    check("restart_addr1", {27'd0, o_d_addr, o_d_data}, {27'd0, 5'd1, 32'h01010101});
`endif
    i_d_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
